// File: rtl/tpu_dac_pkg.sv
// Shared types and constants for the DAC lane packer: lane geometry, FSM encoding and output word layout.
package tpu_dac_pkg;

    localparam int LANES = 8;
    localparam int SW    = 16;
    localparam int NLANE = 2 * LANES;

    typedef logic [SW-1:0] sample_t;

    localparam sample_t                IDLE_CODE = 16'h0000;
    localparam logic [LANES*SW-1:0]    IDLE_WORD = {LANES{IDLE_CODE}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        RUN    = 3'd2,
        UNDER  = 3'd3,
        RESYNC = 3'd4
    } dac_state_e;

    typedef struct packed {
        logic                tvalid;
        logic                tlast;
        logic                tfill;
        logic [LANES*SW-1:0] tdataI;
        logic [LANES*SW-1:0] tdataQ;
    } dac_out_t;

endpackage

// File: rtl/tpu_dac_lane_resync.sv
// Per-lane frame drain: while resyncing, the lane pulls and drops samples until its own tlast goes by.
// Combinational ready (valid-independent); done flag registered, cleared while the FSM sits in ARM.
module tpu_dac_lane_resync (
    input  logic clk_250m,
    input  logic reset_n,
    input  logic i_resync,
    input  logic i_preset,
    input  logic i_clear,
    input  logic i_tvalid,
    input  logic i_tlast,
    output logic o_tready,
    output logic o_done
);

    logic r_done;
    logic w_last_seen;

    assign o_tready    = i_resync & ~r_done;
    assign w_last_seen = i_tvalid & o_tready & i_tlast;
    assign o_done      = r_done;

    // Preset covers lanes whose tlast was consumed by the misaligned word itself.
    always_ff @(posedge clk_250m or negedge reset_n) begin
        if (!reset_n) begin
            r_done <= 1'b0;
        end else if (i_clear) begin
            r_done <= 1'b0;
        end else if (i_preset || w_last_seen) begin
            r_done <= 1'b1;
        end
    end

endmodule

// File: rtl/tpu_dac_lane_packer.sv
// Joins 8 I + 8 Q sample lanes in lockstep into 128-bit I/Q DAC words; 1-cycle registered output.
// DAC side never stalls (filler on starvation); lanes see all-or-none ready. TPU_DAC_STATS_EN adds counters.
module tpu_dac_lane_packer
    import tpu_dac_pkg::*;
(
    input  logic                        clk_250m,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [LANES-1:0]            s_axis_inI_tvalid,
    output logic [LANES-1:0]            s_axis_inI_tready,
    input  logic [LANES-1:0][SW-1:0]    s_axis_inI_tdata,
    input  logic [LANES-1:0]            s_axis_inI_tlast,
    input  logic [LANES-1:0]            s_axis_inQ_tvalid,
    output logic [LANES-1:0]            s_axis_inQ_tready,
    input  logic [LANES-1:0][SW-1:0]    s_axis_inQ_tdata,
    input  logic [LANES-1:0]            s_axis_inQ_tlast,
    output logic                        m_axis_dac_tvalid,
    output logic [LANES*SW-1:0]         m_axis_dac_tdataI,
    output logic [LANES*SW-1:0]         m_axis_dac_tdataQ,
    output logic                        m_axis_dac_tlast,
    output logic                        m_axis_dac_tfill,
    output logic [2:0]                  state_o,
`ifdef TPU_DAC_STATS_EN
    output logic [31:0]                 underrun_cnt,
    output logic [31:0]                 frame_cnt,
    output logic [15:0]                 resync_cnt,
`endif
    output logic                        align_err
);

    dac_state_e         r_state;
    dac_state_e         w_next;
    dac_out_t           r_out;
    dac_out_t           w_out;
    logic               r_mid_frame;
    logic               r_align_err;

    logic [NLANE-1:0]   w_vld;
    logic [NLANE-1:0]   w_last;
    logic [NLANE-1:0]   w_rdy;
    logic [NLANE-1:0]   w_rs_rdy;
    logic [NLANE-1:0]   w_done;
    logic               w_all_valid;
    logic               w_active;
    logic               w_xfer;
    logic               w_align_bad;
    logic               w_good;
    logic               w_rs_en;
    logic               w_rs_clear;

    // Lanes 0..LANES-1 are the I rail, LANES..2*LANES-1 the Q rail.
    assign w_vld       = {s_axis_inQ_tvalid, s_axis_inI_tvalid};
    assign w_last      = {s_axis_inQ_tlast,  s_axis_inI_tlast};
    assign w_all_valid = &w_vld;
    assign w_active    = enable && (r_state == RUN || r_state == UNDER);
    assign w_xfer      = w_active && w_all_valid;
    assign w_align_bad = w_xfer && (|w_last) && !(&w_last);
    assign w_good      = w_xfer && !w_align_bad;
    assign w_rs_en     = enable && (r_state == RESYNC);
    assign w_rs_clear  = (r_state == ARM);

    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        tpu_dac_lane_resync u_resync (
            .clk_250m (clk_250m),
            .reset_n  (reset_n),
            .i_resync (w_rs_en),
            .i_preset (w_align_bad && w_last[k]),
            .i_clear  (w_rs_clear),
            .i_tvalid (w_vld[k]),
            .i_tlast  (w_last[k]),
            .o_tready (w_rs_rdy[k]),
            .o_done   (w_done[k])
        );
        assign w_rdy[k] = w_active ? w_all_valid : w_rs_rdy[k];
    end

    assign s_axis_inI_tready = w_rdy[LANES-1:0];
    assign s_axis_inQ_tready = w_rdy[NLANE-1:LANES];

    // Disable beats everything; a misaligned word beats a normal transfer.
    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next = r_mid_frame ? RESYNC : ARM;
                ARM:     if (w_all_valid) w_next = RUN;
                RUN:     if (w_align_bad) w_next = RESYNC;
                         else if (!w_all_valid) w_next = UNDER;
                UNDER:   if (w_align_bad) w_next = RESYNC;
                         else if (w_all_valid) w_next = RUN;
                RESYNC:  if (&w_done) w_next = ARM;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_out = '{tvalid: 1'b0, tlast: 1'b0, tfill: 1'b0, tdataI: IDLE_WORD, tdataQ: IDLE_WORD};
        if (enable && r_state != IDLE) begin
            w_out.tvalid = 1'b1;
            if (w_good) begin
                w_out.tdataI = s_axis_inI_tdata;
                w_out.tdataQ = s_axis_inQ_tdata;
                w_out.tlast  = s_axis_inI_tlast[0];
            end else begin
                w_out.tfill  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_250m or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_out       <= '{tvalid: 1'b0, tlast: 1'b0, tfill: 1'b0, tdataI: IDLE_WORD, tdataQ: IDLE_WORD};
            r_mid_frame <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_out   <= w_out;
            if (w_xfer) begin
                r_mid_frame <= ~s_axis_inI_tlast[0];
            end
            if (w_align_bad) begin
                r_align_err <= 1'b1;
            end
        end
    end

    assign m_axis_dac_tvalid = r_out.tvalid;
    assign m_axis_dac_tdataI = r_out.tdataI;
    assign m_axis_dac_tdataQ = r_out.tdataQ;
    assign m_axis_dac_tlast  = r_out.tlast;
    assign m_axis_dac_tfill  = r_out.tfill;
    assign state_o           = r_state;
    assign align_err         = r_align_err;

`ifdef TPU_DAC_STATS_EN
    logic [31:0] r_underrun_cnt;
    logic [31:0] r_frame_cnt;
    logic [15:0] r_resync_cnt;

    always_ff @(posedge clk_250m or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun_cnt <= '0;
            r_frame_cnt    <= '0;
            r_resync_cnt   <= '0;
        end else begin
            if (r_state == RUN && w_next == UNDER && r_underrun_cnt != '1) begin
                r_underrun_cnt <= r_underrun_cnt + 32'd1;
            end
            if (w_xfer && s_axis_inI_tlast[0] && r_frame_cnt != '1) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
            if (r_state != RESYNC && w_next == RESYNC && r_resync_cnt != '1) begin
                r_resync_cnt <= r_resync_cnt + 16'd1;
            end
        end
    end

    assign underrun_cnt = r_underrun_cnt;
    assign frame_cnt    = r_frame_cnt;
    assign resync_cnt   = r_resync_cnt;
`endif

endmodule

// File: tb/tb_tpu_dac_lane_packer.sv
// Scoreboard bench for tpu_dac_lane_packer: frame-level reference model feeds an expected-word queue,
// a negedge monitor pops and compares every payload word and checks every filler word.
`timescale 1ns/1ps
module tb_tpu_dac_lane_packer;
    import tpu_dac_pkg::*;

    localparam int NL   = 16;
    localparam int MAXW = 64;
    localparam logic [127:0] IDLE_W = {8{16'h0000}};

    typedef struct packed {
        logic         last;
        logic [127:0] i;
        logic [127:0] q;
    } exp_t;

    logic clk_250m = 1'b0;
    logic reset_n;
    logic enable;
    logic [7:0] iv, ir, il, qv, qr, ql;
    logic [7:0][15:0] id, qd;
    logic m_tvalid, m_tlast, m_tfill, align_err;
    logic [127:0] m_di, m_dq;
    logic [2:0] st;
`ifdef TPU_DAC_STATS_EN
    logic [31:0] underrun_cnt, frame_cnt;
    logic [15:0] resync_cnt;
`endif

    always #5 clk_250m = ~clk_250m;

    tpu_dac_lane_packer dut (
        .clk_250m          (clk_250m),
        .reset_n           (reset_n),
        .enable            (enable),
        .s_axis_inI_tvalid (iv),
        .s_axis_inI_tready (ir),
        .s_axis_inI_tdata  (id),
        .s_axis_inI_tlast  (il),
        .s_axis_inQ_tvalid (qv),
        .s_axis_inQ_tready (qr),
        .s_axis_inQ_tdata  (qd),
        .s_axis_inQ_tlast  (ql),
        .m_axis_dac_tvalid (m_tvalid),
        .m_axis_dac_tdataI (m_di),
        .m_axis_dac_tdataQ (m_dq),
        .m_axis_dac_tlast  (m_tlast),
        .m_axis_dac_tfill  (m_tfill),
        .state_o           (st),
`ifdef TPU_DAC_STATS_EN
        .underrun_cnt      (underrun_cnt),
        .frame_cnt         (frame_cnt),
        .resync_cnt        (resync_cnt),
`endif
        .align_err         (align_err)
    );

    int vectors = 0;
    int errors  = 0;

    logic [16:0]  lq [NL][$];
    exp_t         exp_q[$];
    int           hold [NL];
    int           stall_pct = 0;
    logic [15:0]  fd [NL][MAXW];
    bit           fl [NL][MAXW];
    int           flen [NL];
    int           n_payload = 0;
    int           cur_gap = 0;
    int           gap_log[$];
    bit           seen [5];

    task automatic chk(input string nm, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic chk_w(input string nm, input logic [256:0] act, input logic [256:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Lane k sample in sequential frames is k*16+n (Q rail offset by 0x100).
    task automatic gen_frame(input int len, input int short_lane, input bit seq);
        for (int l = 0; l < NL; l++) begin
            flen[l] = (l == short_lane) ? len - 1 : len;
            for (int n = 0; n < len; n++) begin
                fd[l][n] = seq ? 16'((l % 8) * 16 + n + ((l >= 8) ? 256 : 0)) : 16'($urandom);
                fl[l][n] = (n == flen[l] - 1);
            end
        end
    endtask

    task automatic load(input int n0, input int n1);
        for (int l = 0; l < NL; l++)
            for (int n = n0; n <= n1 && n < flen[l]; n++)
                lq[l].push_back({fl[l][n], fd[l][n]});
    endtask

    // Words are emitted while every lane has word n and all tlasts agree; the rest of the frame is dropped.
    task automatic expect_frame(input int n0, input int n1);
        for (int n = n0; n <= n1; n++) begin
            bit   ok;
            exp_t e;
            ok = 1'b1;
            for (int l = 0; l < NL; l++) begin
                if (n >= flen[l]) ok = 1'b0;
                else if (fl[l][n] != fl[0][n]) ok = 1'b0;
            end
            if (!ok) break;
            for (int k = 0; k < 8; k++) begin
                e.i[k*16 +: 16] = fd[k][n];
                e.q[k*16 +: 16] = fd[k+8][n];
            end
            e.last = fl[0][n];
            exp_q.push_back(e);
        end
    endtask

    function automatic int gap_sum(input int from, input int to);
        int s = 0;
        for (int g = from; g <= to; g++)
            s += (g < gap_log.size()) ? gap_log[g] : 1000;
        return s;
    endfunction

    task automatic wait_drain(input string nm, input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk_250m); #1;
            c++;
        end
        chk(nm, exp_q.size(), 0);
        @(posedge clk_250m); #1;
    endtask

    task automatic wait_payload(input string nm, input int target, input int budget);
        int c = 0;
        while (n_payload < target && c < budget) begin
            @(posedge clk_250m); #1;
            c++;
        end
        chk(nm, int'(n_payload >= target), 1);
    endtask

    // Lane driver: presents the head of each lane queue, pops on handshake just before the edge.
    initial begin
        iv = '0; qv = '0; il = '0; ql = '0; id = '0; qd = '0;
        for (int l = 0; l < NL; l++) hold[l] = 0;
        forever begin
            @(negedge clk_250m);
            for (int l = 0; l < NL; l++) begin
                logic        v;
                logic [16:0] w;
                v = (lq[l].size() > 0) && (hold[l] == 0) &&
                    !(stall_pct > 0 && $urandom_range(99) < stall_pct);
                if (hold[l] > 0) hold[l]--;
                w = (lq[l].size() > 0) ? lq[l][0] : 17'h0;
                if (l < 8) begin
                    iv[l] = v; id[l] = w[15:0]; il[l] = w[16];
                end else begin
                    qv[l-8] = v; qd[l-8] = w[15:0]; ql[l-8] = w[16];
                end
            end
            #4;
            for (int l = 0; l < NL; l++) begin
                if (l < 8 ? (iv[l] && ir[l]) : (qv[l-8] && qr[l-8]))
                    if (lq[l].size() > 0) void'(lq[l].pop_front());
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk_250m);
            if (int'(st) < 5) seen[st] = 1'b1;
            if (!reset_n) begin
                cur_gap = 0;
            end else if (m_tvalid) begin
                if (m_tfill) begin
                    cur_gap++;
                    chk_w("filler_word", {m_tlast, m_di, m_dq}, {1'b0, IDLE_W, IDLE_W});
                end else begin
                    gap_log.push_back(cur_gap);
                    cur_gap = 0;
                    n_payload++;
                    if (exp_q.size() == 0) begin
                        chk_w("unexpected_payload", {m_tlast, m_di, m_dq}, '0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk_w("payload", {m_tlast, m_di, m_dq}, {e.last, e.i, e.q});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, n0, viol, cnt, nz;
`ifdef TPU_DAC_STATS_EN
        int u0, f0;
`endif
        reset_n = 1'b0;
        enable  = 1'b0;
        #12;
        chk("rst_tvalid", int'(m_tvalid), 0);
        chk("rst_tready", int'({qr, ir}), 0);
        chk("rst_state", int'(st), 0);
        chk("rst_align_err", int'(align_err), 0);
        chk("rst_last_fill", int'({m_tlast, m_tfill}), 0);
        chk_w("rst_data", {1'b0, m_di, m_dq}, {1'b0, IDLE_W, IDLE_W});
        @(posedge clk_250m); #3 reset_n = 1'b1;

        // Basic 4-word frame: one ARM filler then four back-to-back payload words.
        gen_frame(4, -1, 1'b1); load(0, 3); expect_frame(0, 3);
        g0 = gap_log.size();
        @(posedge clk_250m); #1 enable = 1'b1;
        wait_drain("basic_drain", 60);
        chk("basic_arm_filler", gap_sum(g0, g0), 1);
        chk("basic_b2b", gap_sum(g0 + 1, g0 + 3), 0);
        @(posedge clk_250m); #1;
        chk("starved_state", int'(st), int'(UNDER));

        // Q3 withheld for 5 cycles mid-frame.
`ifdef TPU_DAC_STATS_EN
        u0 = underrun_cnt;
`endif
        gen_frame(8, -1, 1'b1); load(0, 7); expect_frame(0, 7);
        g0 = gap_log.size();
        n0 = n_payload;
        wait_payload("underrun_start", n0 + 3, 60);
        hold[8 + 3] = 5;
        wait_drain("underrun_drain", 80);
        chk("underrun_fillers", gap_sum(g0 + 1, g0 + 7), 5);
`ifdef TPU_DAC_STATS_EN
        // One entry from the stall, one when the lanes run dry after the frame.
        chk("underrun_cnt", int'(underrun_cnt - u0), 2);
`endif

        // I5 ends its frame one word early.
        for (int s = 0; s < 5; s++) seen[s] = 1'b0;
        gen_frame(4, 5, 1'b1); load(0, 3); expect_frame(0, 3);
        gen_frame(4, -1, 1'b0); load(0, 3); expect_frame(0, 3);
        wait_drain("misalign_drain", 120);
        chk("align_err_set", int'(align_err), 1);
        chk("misalign_resync_seen", int'(seen[RESYNC]), 1);

        // enable dropped after word 2 of 4, raised again 10 cycles later.
        gen_frame(4, -1, 1'b1); load(0, 1); expect_frame(0, 1);
        wait_drain("en_pre_drain", 60);
        @(posedge clk_250m); #1 enable = 1'b0;
        load(2, 3);
        gen_frame(4, -1, 1'b0); load(0, 3); expect_frame(0, 3);
        @(posedge clk_250m);
        @(negedge clk_250m);
        chk("en_off_tvalid", int'(m_tvalid), 0);
        chk("en_off_state", int'(st), int'(IDLE));
        chk("en_off_tready", int'({qr, ir}), 0);
        for (int s = 0; s < 5; s++) seen[s] = 1'b0;
        viol = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_250m);
            if (m_tvalid || ({qr, ir} != '0)) viol++;
        end
        chk("disabled_quiet", viol, 0);
        @(posedge clk_250m); #1 enable = 1'b1;
        wait_drain("en_post_drain", 120);
        chk("en_resync_seen", int'(seen[RESYNC]), 1);

        // Random frame lengths, random data, random per-lane stalls.
        stall_pct = 3;
        for (int f = 0; f < 20; f++) begin
            gen_frame($urandom_range(12, 1), -1, 1'b0);
            load(0, MAXW - 1);
            expect_frame(0, MAXW - 1);
        end
        wait_drain("random_drain", 4000);
        stall_pct = 0;

        // 1000 continuous words.
`ifdef TPU_DAC_STATS_EN
        f0 = frame_cnt;
`endif
        for (int f = 0; f < 125; f++) begin
            gen_frame(8, -1, 1'b0); load(0, 7); expect_frame(0, 7);
        end
        g0 = gap_log.size();
        wait_drain("b2b_drain", 1500);
        cnt = gap_log.size() - g0;
        nz = 0;
        for (int g = g0 + 1; g < gap_log.size(); g++) if (gap_log[g] != 0) nz++;
        chk("b2b_words", cnt, 1000);
        chk("b2b_no_filler", nz, 0);
`ifdef TPU_DAC_STATS_EN
        chk("frame_cnt", int'(frame_cnt - f0), 125);
`endif

        // Asynchronous reset in the middle of a long frame.
        gen_frame(40, -1, 1'b0); load(0, 39); expect_frame(0, 39);
        n0 = n_payload;
        wait_payload("rst_run_start", n0 + 5, 80);
        @(posedge clk_250m); #3 reset_n = 1'b0;
        #1;
        chk("arst_tvalid", int'(m_tvalid), 0);
        chk("arst_state", int'(st), int'(IDLE));
        chk("arst_align_err", int'(align_err), 0);
        chk("arst_tready", int'({qr, ir}), 0);
        chk_w("arst_out", {m_tfill, m_di, m_dq}, {1'b0, IDLE_W, IDLE_W});
        enable = 1'b0;
        for (int l = 0; l < NL; l++) begin
            lq[l].delete();
            hold[l] = 0;
        end
        exp_q.delete();
        repeat (2) @(posedge clk_250m);
        #3 reset_n = 1'b1;

        // Fresh frame after reset: mid-frame history is gone, so straight to ARM.
        for (int s = 0; s < 5; s++) seen[s] = 1'b0;
        gen_frame(4, -1, 1'b1); load(0, 3); expect_frame(0, 3);
        g0 = gap_log.size();
        @(posedge clk_250m); #1 enable = 1'b1;
        wait_drain("post_rst_drain", 60);
        chk("post_rst_arm_filler", gap_sum(g0, g0), 1);
        chk("post_rst_no_resync", int'(seen[RESYNC]), 0);
        chk("post_rst_align_err", int'(align_err), 0);

        repeat (3) @(posedge clk_250m);
        chk("final_exp_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
